// File: rtl/reset_run_sequencer.sv
// Bring-up sequencer: holds a registered system reset, opens a bounded run
// window with a divided tick strobe, then reports completion until restarted.
module reset_run_sequencer #(
    parameter int HOLD_CYCLES = 5,
    parameter int RUN_CYCLES  = 8,
    parameter int TICK_DIV    = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             abort_i,
    output logic             sys_reset_o,
    output logic             run_o,
    output logic             tick_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] cycle_count_o
);

    typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             sys_reset_q, sys_reset_d;
    logic             run_q, run_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Abort outranks terminal count, which outranks start; the RUN count
    // advances on every RUN edge, including the one that aborts.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        phase_d = phase_q;
        count_d = count_q;
        tick_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = HOLD;
                    hold_d  = CNT_W'(1);
                    count_d = '0;
                end
            end
            HOLD: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = RUN;
                    tick_d  = (TICK_LAST == '0);
                    phase_d = (TICK_LAST == '0) ? '0 : CNT_W'(1);
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            RUN: begin
                if (count_q != CNT_MAX) begin
                    count_d = count_q + 1'b1;
                end
                if (abort_i) begin
                    state_d = IDLE;
                end else if (count_q == RUN_LAST) begin
                    state_d = DONE;
                end else begin
                    tick_d  = (phase_q == TICK_LAST);
                    phase_d = (phase_q == TICK_LAST) ? '0 : phase_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        sys_reset_d = (state_d != RUN);
        run_d       = (state_d == RUN);
        busy_d      = (state_d == HOLD) || (state_d == RUN);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            phase_q     <= '0;
            count_q     <= '0;
            tick_q      <= 1'b0;
            sys_reset_q <= 1'b1;
            run_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            phase_q     <= phase_d;
            count_q     <= count_d;
            tick_q      <= tick_d;
            sys_reset_q <= sys_reset_d;
            run_q       <= run_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign sys_reset_o   = sys_reset_q;
    assign run_o         = run_q;
    assign tick_o        = tick_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign cycle_count_o = count_q;

endmodule
